// File: rtl/hazard_ctrl_if.sv
// ID-stage to hazard-controller bundle: decoded source/destination fields in,
// forwarding selects and ID/EX boundary control out.
interface hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_load;
    logic              br_taken;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic              flush;
    logic              issue;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr, id_rd, id_is_load, br_taken,
        input  fwd_a_sel, fwd_b_sel, stall, flush, issue, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr, id_rd, id_is_load, br_taken,
        output fwd_a_sel, fwd_b_sel, stall, flush, issue, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the ID/EX boundary of a 5-stage pipeline.
// Define HAZ_FWD_EN for operand forwarding; otherwise RAW hazards stall until the writer reaches WB.
module hazard_ctrl #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic          CLOCK,
    input  logic          CLEAR,
    hazard_ctrl_if.slave  bus
);

    // The WB entry never influences control (the register file writes before
    // it reads), so only the EX and MEM destinations are kept.
    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
    } dst_t;

    dst_t             ex_q, ex_d;
    dst_t             mem_q, mem_d;
    logic             ex_load_q, ex_load_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic load_use, hazard;
    logic stall, flush, issue;

    function automatic logic src_hit(input logic used, input logic [REG_AW-1:0] src,
                                     input dst_t stg);
        return used && (src != '0) && stg.valid && stg.wr && (stg.rd == src);
    endfunction

    always_comb begin
        rs_ex    = src_hit(bus.id_use_rs, bus.id_rs, ex_q);
        rt_ex    = src_hit(bus.id_use_rt, bus.id_rt, ex_q);
        rs_mem   = src_hit(bus.id_use_rs, bus.id_rs, mem_q);
        rt_mem   = src_hit(bus.id_use_rt, bus.id_rt, mem_q);
        load_use = ex_load_q & (rs_ex | rt_ex);
`ifdef HAZ_FWD_EN
        hazard   = load_use;
`else
        hazard   = load_use | rs_ex | rt_ex | rs_mem | rt_mem;
`endif
        // An empty ID slot has nothing to protect, so it never stalls.
        flush = ~CLEAR & bus.br_taken;
        stall = ~CLEAR & ~bus.br_taken & bus.id_valid & hazard;
        issue = ~CLEAR & bus.id_valid & ~stall & ~flush;
    end

    always_comb begin
        mem_d     = ex_q;
        ex_d      = '0;
        ex_load_d = 1'b0;
        fwd_a_d   = 2'b00;
        fwd_b_d   = 2'b00;
        cnt_d     = cnt_q;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.wr    = bus.id_wr;
            ex_d.rd    = bus.id_rd;
            ex_load_d  = bus.id_is_load;
`ifdef HAZ_FWD_EN
            // Youngest producer wins when both EX and MEM match.
            fwd_a_d = rs_ex ? 2'b01 : (rs_mem ? 2'b10 : 2'b00);
            fwd_b_d = rt_ex ? 2'b01 : (rt_mem ? 2'b10 : 2'b00);
`endif
        end
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            ex_q      <= '0;
            mem_q     <= '0;
            ex_load_q <= 1'b0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            ex_load_q <= ex_load_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.issue       = issue;
    assign bus.fwd_a_sel   = fwd_a_q;
    assign bus.fwd_b_sel   = fwd_b_q;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a queue-based model of the instructions in flight.
module tb_hazard_ctrl;

    localparam int REG_AW  = 4;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic clear = 1'b1;

    hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .CLOCK (clk),
        .CLEAR (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit wr;
        int rd;
        bit ld;
        bit urs;
        int rs;
        bit urt;
        int rt;
    } ins_t;

    // One instruction in flight in the model; sa/sb are the selects it must see in EX.
    typedef struct {
        bit v;
        bit wr;
        int rd;
        bit ld;
        int sa;
        int sb;
    } rec_t;

    rec_t pipe[$];          // pipe[0] = EX, pipe[1] = MEM
    int   cnt_m;
    bit   model_ok;
    int   n_pass;
    int   n_fail;
    int   n_total;

    logic       last_stall, last_flush, last_issue;
    logic [1:0] last_sa, last_sb;

    const ins_t NOP = '{default: 0};

    function automatic ins_t alu(int rd, int rs, int rt);
        return '{v: 1, wr: 1, rd: rd, ld: 0, urs: 1, rs: rs, urt: 1, rt: rt};
    endfunction

    function automatic ins_t lw(int rd, int rs);
        return '{v: 1, wr: 1, rd: rd, ld: 1, urs: 1, rs: rs, urt: 0, rt: 0};
    endfunction

    function automatic bit hit(rec_t r, bit used, int src);
        return used && (src != 0) && r.v && r.wr && (r.rd == src);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one ID-cycle of stimulus, compare at the falling edge, advance the model.
    task automatic step(string tag, ins_t i, bit br, bit clr);
        rec_t ex, mem, nw;
        bit   haz, e_stall, e_flush, e_issue;
        int   sa, sb;
        bus.id_valid   = i.v;
        bus.id_rs      = i.rs[REG_AW-1:0];
        bus.id_rt      = i.rt[REG_AW-1:0];
        bus.id_use_rs  = i.urs;
        bus.id_use_rt  = i.urt;
        bus.id_wr      = i.wr;
        bus.id_rd      = i.rd[REG_AW-1:0];
        bus.id_is_load = i.ld;
        bus.br_taken   = br;
        clear          = clr;
        ex  = pipe[0];
        mem = pipe[1];
`ifdef HAZ_FWD_EN
        haz = ex.ld && (hit(ex, i.urs, i.rs) || hit(ex, i.urt, i.rt));
        sa  = hit(ex, i.urs, i.rs) ? 1 : (hit(mem, i.urs, i.rs) ? 2 : 0);
        sb  = hit(ex, i.urt, i.rt) ? 1 : (hit(mem, i.urt, i.rt) ? 2 : 0);
`else
        haz = hit(ex, i.urs, i.rs) || hit(ex, i.urt, i.rt) ||
              hit(mem, i.urs, i.rs) || hit(mem, i.urt, i.rt);
        sa  = 0;
        sb  = 0;
`endif
        e_flush = !clr && br;
        e_stall = !clr && !br && i.v && haz;
        e_issue = !clr && i.v && !e_stall && !e_flush;
        @(negedge clk);
        last_stall = bus.stall;
        last_flush = bus.flush;
        last_issue = bus.issue;
        last_sa    = bus.fwd_a_sel;
        last_sb    = bus.fwd_b_sel;
        chk({tag, "_stall"}, bus.stall, e_stall);
        chk({tag, "_flush"}, bus.flush, e_flush);
        chk({tag, "_issue"}, bus.issue, e_issue);
        if (model_ok) begin
            chk({tag, "_sel_a"}, bus.fwd_a_sel, ex.sa);
            chk({tag, "_sel_b"}, bus.fwd_b_sel, ex.sb);
            chk({tag, "_count"}, bus.stall_count, cnt_m);
        end
        @(posedge clk);
        if (clr) begin
            pipe     = '{'{default: 0}, '{default: 0}};
            cnt_m    = 0;
            model_ok = 1'b1;
        end else begin
            nw = '{default: 0};
            if (e_issue) nw = '{v: 1, wr: i.wr, rd: i.rd, ld: i.ld, sa: sa, sb: sb};
            pipe.push_front(nw);
            void'(pipe.pop_back());
            if (e_stall && cnt_m < CNT_MAX) cnt_m++;
        end
        #1;
    endtask

    task automatic do_reset(string tag);
        step(tag, alu(3, 4, 5), 1'b1, 1'b1);
        step(tag, alu(3, 4, 5), 1'b1, 1'b1);
        chk({tag, "_sel_a_lit"}, bus.fwd_a_sel, 0);
        chk({tag, "_sel_b_lit"}, bus.fwd_b_sel, 0);
        chk({tag, "_count_lit"}, bus.stall_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ins_t r;
        bit   br, clr;
        n_pass   = 0;
        n_fail   = 0;
        n_total  = 0;
        cnt_m    = 0;
        model_ok = 1'b0;
        pipe     = '{'{default: 0}, '{default: 0}};

        do_reset("rst");
        step("first", alu(3, 1, 1), 1'b0, 1'b0);
        chk("first_issue", last_issue, 1);

`ifdef HAZ_FWD_EN
        step("exf_sub", alu(8, 3, 6), 1'b0, 1'b0);
        chk("exf_nostall", last_stall, 0);
        step("exf_ex", NOP, 1'b0, 1'b0);
        chk("exf_sel_a", last_sa, 1);

        step("memf_add", alu(5, 1, 6), 1'b0, 1'b0);
        step("memf_ind", alu(7, 1, 6), 1'b0, 1'b0);
        step("memf_and", alu(9, 6, 5), 1'b0, 1'b0);
        step("memf_ex", NOP, 1'b0, 1'b0);
        chk("memf_sel_b", last_sb, 2);

        step("pri_add1", alu(5, 1, 6), 1'b0, 1'b0);
        step("pri_add2", alu(5, 6, 6), 1'b0, 1'b0);
        step("pri_or", alu(10, 5, 6), 1'b0, 1'b0);
        step("pri_ex", NOP, 1'b0, 1'b0);
        chk("pri_sel_a", last_sa, 1);

        step("lu_lw", lw(2, 1), 1'b0, 1'b0);
        step("lu_use0", alu(11, 2, 6), 1'b0, 1'b0);
        chk("lu_stall", last_stall, 1);
        chk("lu_hold", last_issue, 0);
        step("lu_use1", alu(11, 2, 6), 1'b0, 1'b0);
        chk("lu_release", last_stall, 0);
        chk("lu_issue", last_issue, 1);
        step("lu_ex", NOP, 1'b0, 1'b0);
        chk("lu_sel_a", last_sa, 2);
        chk("lu_count_lit", bus.stall_count, 1);

        step("fl_lw", lw(2, 1), 1'b0, 1'b0);
        step("fl_br", alu(11, 2, 6), 1'b1, 1'b0);
        chk("fl_flush", last_flush, 1);
        chk("fl_nostall", last_stall, 0);
        chk("fl_noissue", last_issue, 0);
        chk("fl_count_lit", bus.stall_count, 1);
        step("fl_nop", NOP, 1'b0, 1'b0);

        step("r0_lw", lw(0, 1), 1'b0, 1'b0);
        step("r0_use", alu(12, 0, 0), 1'b0, 1'b0);
        chk("r0_nostall", last_stall, 0);
        step("r0_ex", NOP, 1'b0, 1'b0);
        chk("r0_sel_a", last_sa, 0);
        chk("r0_sel_b", last_sb, 0);
`else
        step("nf_use0", alu(8, 3, 6), 1'b0, 1'b0);
        chk("nf_stall0", last_stall, 1);
        step("nf_use1", alu(8, 3, 6), 1'b0, 1'b0);
        chk("nf_stall1", last_stall, 1);
        step("nf_use2", alu(8, 3, 6), 1'b0, 1'b0);
        chk("nf_release", last_stall, 0);
        chk("nf_issue", last_issue, 1);
        step("nf_ex", NOP, 1'b0, 1'b0);
        chk("nf_sel_a", last_sa, 0);
        chk("nf_count_lit", bus.stall_count, 2);

        step("nf_r0_w", alu(0, 1, 1), 1'b0, 1'b0);
        step("nf_r0_use", alu(12, 0, 0), 1'b0, 1'b0);
        chk("nf_r0_nostall", last_stall, 0);
`endif

        do_reset("mc_rst");
        step("mc_lw", lw(2, 1), 1'b0, 1'b0);
        step("mc_clr", alu(11, 2, 6), 1'b0, 1'b1);
        chk("mc_nostall", last_stall, 0);
        chk("mc_count_lit", bus.stall_count, 0);
        step("mc_after", alu(11, 2, 6), 1'b0, 1'b0);
        chk("mc_empty", last_stall, 0);

        do_reset("sat_rst");
        for (int k = 0; k < 40; k++) begin
            step("sat_lw", lw(2, 1), 1'b0, 1'b0);
            for (int j = 0; j < 3; j++) begin
                step("sat_use", alu(11, 2, 6), 1'b0, 1'b0);
                if (!last_stall) break;
            end
        end
        chk("sat_count_lit", bus.stall_count, CNT_MAX);

        do_reset("rnd_rst");
        for (int k = 0; k < 400; k++) begin
            r.v   = ($urandom_range(0, 99) < 85);
            r.wr  = ($urandom_range(0, 99) < 75);
            r.rd  = $urandom_range(0, 3);
            r.ld  = ($urandom_range(0, 99) < 30);
            r.urs = ($urandom_range(0, 99) < 80);
            r.rs  = $urandom_range(0, 3);
            r.urt = ($urandom_range(0, 99) < 60);
            r.rt  = $urandom_range(0, 3);
            br    = ($urandom_range(0, 99) < 8);
            clr   = ($urandom_range(0, 99) < 2);
            step("rnd", r, br, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline datapath. Tracks destination registers of instructions in EX, MEM and WB, drives the 2-bit select lines of the ALU operand forwarding muxes, and generates stall, flush and issue for the ID/EX boundary. It sits beside the ID/EX pipeline register. It owns no data, only control.

## Interface
- REG_AW, 4: register address width; register 0 is hardwired zero.
- CNT_W, 16: width of the stall performance counter.

- CLOCK  in  1  clock; all state updates on rising edge.
- CLEAR  in  1  reset; synchronous, active-high.
- id_valid  in  1  valid instruction present in ID.
- id_rs, id_rt  in  REG_AW  source register addresses.
- id_use_rs, id_use_rt  in  1  source actually read.
- id_wr  in  1  instruction writes a register.
- id_rd  in  REG_AW  destination register.
- id_is_load  in  1  instruction is a load; result is available only at end of MEM.
- br_taken  in  1  branch resolved taken in EX this cycle.
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects for the instruction in EX: 00 reg file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  discard IF/ID contents; insert bubble into EX.
- issue  out  1  ID instruction advances into EX this cycle.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- The block holds a 3-entry stage tracker: EX, MEM and WB. Each entry holds {valid, wr, rd, is_load}.
- Each clock: WB<=MEM, MEM<=EX, EX<=(issue ? ID fields : bubble with valid=0).
- A source matches a stage when: the source is used, the address is nonzero, and stage valid & wr & rd==source.
- Forward select is computed in ID and registered into EX with the instruction:
  - EX match -> 01.
  - else MEM match -> 10.
  - else 00.
  - On an EX and MEM double match, the youngest (EX) wins.
- WB match needs no forwarding. The register file writes before it reads.
- Load-use: if EX is a load and matches either ID source, stall=1 for exactly one cycle. The next cycle the load is in MEM, so the consumer gets sel 10.
- flush = br_taken. Flush has priority over stall: if both conditions hold, stall=0, flush=1, issue=0.
- issue = id_valid & ~stall & ~flush.
- A bubble entering EX registers fwd sels 00.
- stall_count increments on every cycle with stall=1 and saturates at all-ones. It does not wrap.

## Timing
- stall, flush and issue are combinational from the tracker state plus the ID inputs and br_taken, all in the same cycle. They carry no registered delay.
- fwd_a_sel and fwd_b_sel are registered. They are valid during the instruction's EX cycle, one clock after issue.
- Load-use costs exactly 1 bubble cycle. Non-load RAW hazards cost 0 cycles when forwarding is compiled in.
- CLEAR has priority over everything:
  - Next edge: tracker valids=0, fwd sels=00, stall_count=0.
  - While CLEAR is high: stall, flush and issue are forced to 0.
- CLEAR asserted mid-stall abandons the stall. No count increments in that cycle.
- First cycle after CLEAR: the tracker is empty, so stall=0 for any ID instruction.

## Configuration
- HAZ_FWD_EN defined: full forwarding as above.
- HAZ_FWD_EN undefined:
  - fwd sels are held at 00.
  - stall=1 whenever either ID source matches EX or MEM, regardless of load.
  - Worst-case RAW penalty is 2 cycles. The load-use rule is subsumed.
  - Flush priority, issue, stall_count and reset behaviour are unchanged.

## Test plan
- Reset: hold CLEAR 2 cycles with id_valid=1 and br_taken=1 -> stall, flush, issue, sels and stall_count are all 0. First instruction after release: issue=1.
- EX forward: issue add r3, then sub rs=r3 next cycle -> stall=0; fwd_a_sel=01 during sub's EX cycle.
- MEM forward and priority:
  - add r5, independent op, then and rt=r5 -> fwd_b_sel=10.
  - add r5, add r5, then or rs=r5 -> fwd_a_sel=01.
- Load-use: lw r2, then add rs=r2 ->
  - stall=1 and issue=0 for 1 cycle.
  - Then issue=1 and fwd_a_sel=10.
  - stall_count=1.
- Flush over stall: lw r2 with consumer rs=r2 in ID and br_taken=1 in the same cycle -> flush=1, stall=0, issue=0, stall_count unchanged. Also, any source r0 -> never stalls, sel 00.
- Build without HAZ_FWD_EN: add r4, then use r4 -> stall=1 for 2 cycles, sel 00 throughout, stall_count=2.
